hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR, default 5, SHALL set the register-address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the performance-counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a valid instruction.
REQ-007 id_rs1  in  REG_ADDR  ID source register A.
REQ-008 id_rs2  in  REG_ADDR  ID source register B.
REQ-009 id_uses_rs2  in  1  ID instruction reads rs2.
REQ-010 ex_reg_write  in  1  EX instruction writes a register.
REQ-011 ex_is_load  in  1  EX instruction is a load.
REQ-012 ex_rd  in  REG_ADDR  EX destination register.
REQ-013 branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-014 dmem_busy  in  1  data memory cannot complete this cycle.
REQ-015 pc_stall  out  1  hold PC.
REQ-016 if_id_stall  out  1  hold IF/ID register.
REQ-017 id_ex_stall  out  1  hold ID/EX register.
REQ-018 ex_mem_stall  out  1  hold EX/MEM register.
REQ-019 if_id_flush  out  1  load bubble into IF/ID.
REQ-020 id_ex_flush  out  1  load bubble into ID/EX.
REQ-021 pc_redirect  out  1  PC takes branch target.
REQ-022 stall_cycles  out  CNT_W  saturating count of stalled cycles.
REQ-023 flush_events  out  CNT_W  saturating count of taken redirects.

Function
REQ-024 FSM states SHALL be RUN, WAIT_MEM, FLUSH; control outputs are combinational from state and inputs (Mealy).
REQ-025 loaduse = id_valid & ex_is_load & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-026 Priority in RUN and FLUSH SHALL be dmem_busy > branch_taken > loaduse.
REQ-027 RUN, dmem_busy=1: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall; next WAIT_MEM.
REQ-028 RUN, branch_taken=1 (no busy): assert pc_redirect, if_id_flush, id_ex_flush; next FLUSH.
REQ-029 RUN, loaduse=1 (no busy, no branch): assert pc_stall, if_id_stall, id_ex_flush; stay RUN.
REQ-030 RUN, none of the above: all control outputs 0.
REQ-031 WAIT_MEM: all four stall outputs asserted while dmem_busy=1; the cycle dmem_busy=0, no control output is asserted and next state is FLUSH if flush_pending else RUN.
REQ-032 FLUSH (one cycle, squashes the fetch issued before redirect): assert if_id_flush only; branch_taken and loaduse ignored; next RUN.
REQ-033 FLUSH with dmem_busy=1: assert the four stalls, no flush, set flush_pending, next WAIT_MEM.
REQ-034 flush_pending SHALL clear on the cycle its deferred FLUSH state is entered.
REQ-035 stall_cycles SHALL increment by 1 in every cycle pc_stall=1, saturating at 2^CNT_W-1.
REQ-036 flush_events SHALL increment by 1 in every cycle pc_redirect=1, saturating at 2^CNT_W-1.
REQ-037 ex_rd==0 SHALL never raise loaduse.

Reset
REQ-038 rst=0 SHALL immediately force state RUN, flush_pending 0, both counters 0, independent of clk.
REQ-039 While rst=0 all control outputs SHALL be 0 regardless of inputs.
REQ-040 Reset mid-WAIT_MEM or mid-FLUSH SHALL abandon that state; first cycle after release evaluates as RUN.

Verification
REQ-041 ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_valid=1 -> one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles 0->1.
REQ-042 Same as REQ-041 but ex_rd=0 -> all control outputs 0.
REQ-043 branch_taken=1 one cycle in RUN -> cycle 0: pc_redirect, if_id_flush, id_ex_flush; cycle 1: if_id_flush only; cycle 2: all 0; flush_events=1.
REQ-044 dmem_busy=1 for 3 cycles -> four stalls high exactly 3 cycles, stall_cycles=3, state RUN after.
REQ-045 branch_taken then dmem_busy=1 for 2 cycles in FLUSH -> stalls 2 cycles, then one FLUSH cycle (if_id_flush only), then RUN.
REQ-046 CNT_W=4, dmem_busy=1 for 20 cycles -> stall_cycles stops at 15; rst=0 mid-wait -> counters 0, outputs 0 at once.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory wait.
// Mealy control outputs from a RUN/WAIT_MEM/FLUSH state plus saturating stall/redirect counters.
module hazard_ctrl #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_ADDR-1:0] id_rs1,
  input  logic [REG_ADDR-1:0] id_rs2,
  input  logic                id_uses_rs2,
  input  logic                ex_reg_write,
  input  logic                ex_is_load,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic                branch_taken,
  input  logic                dmem_busy,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                id_ex_stall,
  output logic                ex_mem_stall,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                pc_redirect,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_events
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_MEM, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_flush_pending;
  logic             w_pending_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;
  logic             w_loaduse;
  logic             w_stall_all;
  logic             w_pc_stall;
  logic             w_if_id_stall;
  logic             w_id_ex_flush;
  logic             w_if_id_flush;
  logic             w_redirect;

  assign w_loaduse = id_valid & ex_is_load & ex_reg_write & (ex_rd != '0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    w_next         = r_state;
    w_pending_next = r_flush_pending;
    w_stall_all    = 1'b0;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_redirect     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (dmem_busy) begin
          w_stall_all = 1'b1;
          w_next      = S_WAIT_MEM;
        end else if (branch_taken) begin
          w_redirect    = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_next        = S_FLUSH;
        end else if (w_loaduse) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        if (dmem_busy) begin
          w_stall_all = 1'b1;
        end else if (r_flush_pending) begin
          w_next         = S_FLUSH;
          w_pending_next = 1'b0;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FLUSH: begin
        // A stalled squash cycle is replayed once memory frees up.
        if (dmem_busy) begin
          w_stall_all    = 1'b1;
          w_pending_next = 1'b1;
          w_next         = S_WAIT_MEM;
        end else begin
          w_if_id_flush = 1'b1;
          w_next        = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  assign pc_stall     = rst & (w_stall_all | w_pc_stall);
  assign if_id_stall  = rst & (w_stall_all | w_if_id_stall);
  assign id_ex_stall  = rst & w_stall_all;
  assign ex_mem_stall = rst & w_stall_all;
  assign if_id_flush  = rst & w_if_id_flush;
  assign id_ex_flush  = rst & w_id_ex_flush;
  assign pc_redirect  = rst & w_redirect;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_RUN;
      r_flush_pending <= 1'b0;
      r_stall_cycles  <= '0;
      r_flush_events  <= '0;
    end else begin
      r_state         <= w_next;
      r_flush_pending <= w_pending_next;
      if (pc_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (pc_redirect && (r_flush_events != '1))
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with directed and randomized scenarios.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs2, ex_reg_write, ex_is_load, branch_taken, dmem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, pc_redirect;
  logic       pc_stall4, if_id_stall4, id_ex_stall4, ex_mem_stall4, if_id_flush4, id_ex_flush4, pc_redirect4;
  logic [15:0] stall_cycles, flush_events;
  logic [3:0]  stall_cycles4, flush_events4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .id_ex_stall(id_ex_stall4),
    .ex_mem_stall(ex_mem_stall4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .pc_redirect(pc_redirect4), .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, pc_redirect}
  logic [6:0] outs, outs4;
  assign outs  = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, pc_redirect};
  assign outs4 = {pc_stall4, if_id_stall4, id_ex_stall4, ex_mem_stall4, if_id_flush4, id_ex_flush4, pc_redirect4};

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_STALL = 7'b1111000;
  localparam logic [6:0] O_BR    = 7'b0000111;
  localparam logic [6:0] O_SQ    = 7'b0000100;
  localparam logic [6:0] O_LU    = 7'b1100010;

  task automatic idle_inputs();
    id_valid = 0; id_uses_rs2 = 0; ex_reg_write = 0; ex_is_load = 0;
    branch_taken = 0; dmem_busy = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    id_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = rd; id_rs1 = rd;
    id_uses_rs2 = 0; id_rs2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    set_loaduse(5'd3); branch_taken = 1; dmem_busy = 1;
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE); end
    checks++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    @(negedge clk); #1;
    checks++; if (outs4 !== O_NONE) begin failures++; $display("FAIL reset_outs_held got=%b exp=%b", outs4, O_NONE); end
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_loaduse(5'd5);
    #1;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL loaduse_outs got=%b exp=%b", outs, O_LU); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL loaduse_cnt0 got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL loaduse_cnt1 got=%0d exp=1", stall_cycles); end
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL loaduse_after got=%b exp=%b", outs, O_NONE); end
    // rs2 path, only when rs2 is used
    set_loaduse(5'd7); id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs2 = 1;
    #1;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL loaduse_rs2 got=%b exp=%b", outs, O_LU); end
    id_uses_rs2 = 0;
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL loaduse_rs2_unused got=%b exp=%b", outs, O_NONE); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_loaduse(5'd0); id_rs2 = 0; id_uses_rs2 = 1;
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL rd_zero got=%b exp=%b", outs, O_NONE); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rd_zero_cnt got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1;
    #1;
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL branch_c0 got=%b exp=%b", outs, O_BR); end
    @(negedge clk);
    set_loaduse(5'd4); branch_taken = 1;
    #1;
    checks++; if (outs !== O_SQ) begin failures++; $display("FAIL branch_c1 got=%b exp=%b", outs, O_SQ); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL branch_c2 got=%b exp=%b", outs, O_NONE); end
    checks++; if (flush_events !== 16'd1) begin failures++; $display("FAIL branch_events got=%0d exp=1", flush_events); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dmem_busy = 1; branch_taken = (i == 1);
      #1;
      checks++; if (outs !== O_STALL) begin failures++; $display("FAIL memwait_c%0d got=%b exp=%b", i, outs, O_STALL); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL memwait_exit got=%b exp=%b", outs, O_NONE); end
    checks++; if (stall_cycles !== 16'd3) begin failures++; $display("FAIL memwait_cnt got=%0d exp=3", stall_cycles); end
    @(negedge clk);
    set_loaduse(5'd9);
    #1;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL memwait_run got=%b exp=%b", outs, O_LU); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush_wait();
    logic [6:0] exp_seq [6];
    exp_seq = '{O_BR, O_STALL, O_STALL, O_NONE, O_SQ, O_LU};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      case (i)
        0: branch_taken = 1;
        1, 2: dmem_busy = 1;
        4: branch_taken = 1;
        5: set_loaduse(5'd6);
        default: ;
      endcase
      #1;
      checks++; if (outs !== exp_seq[i]) begin failures++; $display("FAIL flushwait_c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (stall_cycles !== 16'd3 || flush_events !== 16'd1) begin failures++;
      $display("FAIL flushwait_cnt got=%0d/%0d exp=3/1", stall_cycles, flush_events); end
  endtask

  task automatic test_saturate();
    do_reset();
    dmem_busy = 1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (stall_cycles4 !== 4'd15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cycles4); end
    checks++; if (stall_cycles !== 16'd20) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cycles); end
    #1;
    rst = 0;
    #1;
    checks++; if (stall_cycles4 !== 4'd0 || stall_cycles !== 16'd0) begin failures++;
      $display("FAIL sat_reset_cnt got=%0d/%0d exp=0/0", stall_cycles4, stall_cycles); end
    checks++; if (outs4 !== O_NONE || outs !== O_NONE) begin failures++;
      $display("FAIL sat_reset_outs got=%b/%b exp=%b", outs4, outs, O_NONE); end
    @(negedge clk);
    rst = 1;
    idle_inputs();
    set_loaduse(5'd1);
    #1;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL reset_midwait_run got=%b exp=%b", outs, O_LU); end
    @(negedge clk);
    idle_inputs();
    branch_taken = 1;
    @(negedge clk);
    branch_taken = 0;
    #2;
    rst = 0;
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (outs !== O_NONE) begin failures++; $display("FAIL reset_midflush got=%b exp=%b", outs, O_NONE); end
    @(negedge clk);
  endtask

  // Reference: "waiting on memory", "one squash cycle owed next", "squash deferred behind memory".
  bit m_waiting, m_squash_due, m_squash_deferred;
  int m_stalls, m_redirects;

  task automatic test_random();
    logic [6:0] exp_o;
    bit lu;
    do_reset();
    m_waiting = 0; m_squash_due = 0; m_squash_deferred = 0; m_stalls = 0; m_redirects = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst          = ($urandom_range(0, 59) != 0);
      id_valid     = $urandom_range(0, 3) != 0;
      ex_is_load   = $urandom_range(0, 1);
      ex_reg_write = $urandom_range(0, 3) != 0;
      id_uses_rs2  = $urandom_range(0, 1);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      branch_taken = $urandom_range(0, 5) == 0;
      dmem_busy    = $urandom_range(0, 4) == 0;
      #1;
      lu = id_valid && ex_is_load && ex_reg_write && ex_rd != 0 &&
           (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
      if (!rst) begin
        m_waiting = 0; m_squash_due = 0; m_squash_deferred = 0; m_stalls = 0; m_redirects = 0;
        exp_o = O_NONE;
      end else if (dmem_busy) exp_o = O_STALL;
      else if (m_waiting) exp_o = O_NONE;
      else if (m_squash_due) exp_o = O_SQ;
      else if (branch_taken) exp_o = O_BR;
      else if (lu) exp_o = O_LU;
      else exp_o = O_NONE;
      checks++; if (outs !== exp_o || outs4 !== exp_o) begin failures++;
        $display("FAIL rand_outs cyc=%0d got=%b/%b exp=%b", cyc, outs, outs4, exp_o); end
      checks++; if (stall_cycles !== 16'(m_stalls) || flush_events !== 16'(m_redirects) ||
                    stall_cycles4 !== 4'(m_stalls > 15 ? 15 : m_stalls) ||
                    flush_events4 !== 4'(m_redirects > 15 ? 15 : m_redirects)) begin failures++;
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d", cyc, stall_cycles, flush_events,
                 stall_cycles4, flush_events4, m_stalls, m_redirects); end
      @(posedge clk);
      if (rst) begin
        if (exp_o[6]) m_stalls++;
        if (exp_o[0]) m_redirects++;
        if (m_waiting) begin
          if (!dmem_busy) begin
            m_waiting = 0; m_squash_due = m_squash_deferred; m_squash_deferred = 0;
          end
        end else if (m_squash_due) begin
          m_squash_due = 0;
          if (dmem_busy) begin m_waiting = 1; m_squash_deferred = 1; end
        end else if (dmem_busy) m_waiting = 1;
        else if (branch_taken) m_squash_due = 1;
      end
      @(negedge clk);
    end
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_mem_wait();
    test_flush_wait();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
